// File: rtl/fifo_wr_arb_ctrl.sv
// fifo_wr_arb_ctrl
// Controller for a 2**ASIZE x DSIZE FIFO memory macro (async read, sync write).
// Two producers share the single write port under round-robin priority; one
// consumer pops the head word, which the macro presents combinationally at
// raddr (first-word fall-through). Occupancy and status are decoded from a
// pair of wrap-bit pointers.
module fifo_wr_arb_ctrl #(
   parameter int DSIZE     = 4,
   parameter int ASIZE     = 7,
   parameter int AFULL_TH  = 120,
   parameter int AEMPTY_TH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [DSIZE-1:0] wdata0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [DSIZE-1:0] wdata1,
   output logic             gnt1,
   input  logic             rd_en,
   input  logic             err_clr,
   output logic             wclken,
   output logic [ASIZE-1:0] waddr,
   output logic [DSIZE-1:0] wdata,
   output logic [ASIZE-1:0] raddr,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [ASIZE:0]   count,
   output logic             udf_err
);

   // Thresholds sized to the occupancy word so the compares are width-matched.
   localparam logic [ASIZE:0] AFULL_V  = AFULL_TH[ASIZE:0];
   localparam logic [ASIZE:0] AEMPTY_V = AEMPTY_TH[ASIZE:0];
   localparam logic [ASIZE:0] PTR_ONE  = {{ASIZE{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ASIZE:0] wptr;
   logic [ASIZE:0] rptr;
   logic           last_gnt;
   logic           pop;
   logic           underflow;

   // Status decode straight from the registered pointers.
   assign count        = wptr - rptr;
   assign empty        = (wptr == rptr);
   assign full         = (wptr[ASIZE] != rptr[ASIZE]) &&
                         (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
   assign almost_full  = (count >= AFULL_V);
   assign almost_empty = (count <= AEMPTY_V);

   assign waddr  = wptr[ASIZE-1:0];
   assign raddr  = rptr[ASIZE-1:0];
   assign wclken = gnt0 | gnt1;
   // Producer 0 data is parked on the bus when nobody is granted.
   assign wdata  = gnt1 ? wdata1 : wdata0;

   assign pop       = rd_en & ~empty;
   assign underflow = rd_en & empty;

   // Round-robin grant: a lone request wins, a tie goes to the producer not served last.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!full) begin
         if (req0 && req1) begin
            if (last_gnt) gnt0 = 1'b1;
            else          gnt1 = 1'b1;
         end else if (req0) begin
            gnt0 = 1'b1;
         end else if (req1) begin
            gnt1 = 1'b1;
         end
      end
   end

   // Write pointer and arbitration history advance only on an accepted write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr     <= '0;
         last_gnt <= 1'b1;
      end else if (wclken) begin
         wptr     <= wptr + PTR_ONE;
         last_gnt <= gnt1;
      end
   end

   // Read pointer advances on a pop of a non-empty queue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rptr <= '0;
      end else if (pop) begin
         rptr <= rptr + PTR_ONE;
      end
   end

   // Sticky underflow flag; a fresh underflow beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         udf_err <= 1'b0;
      end else if (underflow) begin
         udf_err <= 1'b1;
      end else if (err_clr) begin
         udf_err <= 1'b0;
      end
   end

endmodule
